// File: rtl/defines_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : defines_pkg
//  Description : Shared types and widths for the dnn sequencer/aggregator
//                slice: datapath mode encoding, sequencer states and the
//                ReLU / aggregate / output operand widths.
//  Revision    : 1.0  initial release
// ============================================================================
package defines_pkg;

   localparam int RELU_W = 13;   // datapath ReLU activation width (non-negative)
   localparam int AGGR_W = 15;   // aggregate operand width
   localparam int OUT_W  = 21;   // datapath output width
   localparam int X_W    = 7;    // signed input element width

   // Datapath mode driven towards the shared dnn datapath
   typedef enum logic [2:0] {
      DNN_IDLE        = 3'd0,
      DNN0_DNN1_Y_OUT = 3'd1,
      DNN2_DNN3_Y_OUT = 3'd2,
      DNN_AGGR        = 3'd3,
      FINAL_OUT       = 3'd4
   } dnn_state_t;

   // Sequencer states
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S_Y0   = 3'd1,
      S_Y1   = 3'd2,
      S_AGG  = 3'd3,
      S_OUT  = 3'd4,
      S_CAPT = 3'd5,
      S_HOLD = 3'd6
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/dnn_aggr_unit.sv
`default_nettype none
// ============================================================================
//  Module      : dnn_aggr_unit
//  Description : Combinational per-neuron aggregation over four lanes.
//                sum[k] = zext(a[k]) + zext(b[k])   (max 8190, cannot overflow)
//                mx[k]  = zext(max(a[k], b[k]))
//  Ports       : a, b   - four 13-bit non-negative activations per pass
//                sum,mx - four 15-bit aggregate operands each
//  Revision    : 1.0  initial release
// ============================================================================
module dnn_aggr_unit
   import defines_pkg::*;
(
   input  logic [3:0][RELU_W-1:0] a,
   input  logic [3:0][RELU_W-1:0] b,
   output logic [3:0][AGGR_W-1:0] sum,
   output logic [3:0][AGGR_W-1:0] mx
);

   generate
      for (genvar k = 0; k < 4; k++) begin : g_lane
         logic [AGGR_W-1:0] w_a;
         logic [AGGR_W-1:0] w_b;
         assign w_a    = {{(AGGR_W-RELU_W){1'b0}}, a[k]};
         assign w_b    = {{(AGGR_W-RELU_W){1'b0}}, b[k]};
         assign sum[k] = w_a + w_b;
         assign mx[k]  = (w_a >= w_b) ? w_a : w_b;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/dnn_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dnn_seq_ctrl
//  Description : Sequencer/aggregator for the shared dnn datapath. Accepts a
//                sample (valid/ready), runs pass A and pass B, combines the
//                ReLU activations into sum/max aggregate operands, triggers
//                the final pass and returns four results (valid/ready).
//  Ports       : clk, rst              - clock, sync active-high reset
//                in_valid/in_ready     - sample handshake, x_in = {x3..x0}
//                x0..x3, wsel          - latched sample and weight bank
//                dnn_state             - datapath mode
//                y4..y7_relu           - datapath activations
//                y*_n0_aggr/y*_n1_aggr - sum / max aggregate operands
//                out*, out*_ready      - datapath results and flags
//                res_valid/res_ready   - result handshake, res* held results
//                seq_err, done_cnt     - sticky capture error, sample count
//  Revision    : 1.0  initial release
// ============================================================================
module dnn_seq_ctrl
   import defines_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4*X_W-1:0]   x_in,
   output logic [X_W-1:0]     x0,
   output logic [X_W-1:0]     x1,
   output logic [X_W-1:0]     x2,
   output logic [X_W-1:0]     x3,
   output logic               wsel,
   output dnn_state_t         dnn_state,
   input  logic [RELU_W-1:0]  y4_relu,
   input  logic [RELU_W-1:0]  y5_relu,
   input  logic [RELU_W-1:0]  y6_relu,
   input  logic [RELU_W-1:0]  y7_relu,
   output logic [AGGR_W-1:0]  y4_n0_aggr,
   output logic [AGGR_W-1:0]  y5_n0_aggr,
   output logic [AGGR_W-1:0]  y6_n0_aggr,
   output logic [AGGR_W-1:0]  y7_n0_aggr,
   output logic [AGGR_W-1:0]  y4_n1_aggr,
   output logic [AGGR_W-1:0]  y5_n1_aggr,
   output logic [AGGR_W-1:0]  y6_n1_aggr,
   output logic [AGGR_W-1:0]  y7_n1_aggr,
   input  logic [OUT_W-1:0]   out0_n0,
   input  logic [OUT_W-1:0]   out1_n0,
   input  logic [OUT_W-1:0]   out0_n1,
   input  logic [OUT_W-1:0]   out1_n1,
   input  logic               out0_n0_ready,
   input  logic               out1_n0_ready,
   input  logic               out0_n1_ready,
   input  logic               out1_n1_ready,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [OUT_W-1:0]   res0_n0,
   output logic [OUT_W-1:0]   res1_n0,
   output logic [OUT_W-1:0]   res0_n1,
   output logic [OUT_W-1:0]   res1_n1,
   output logic               seq_err,
   output logic [CNT_W-1:0]   done_cnt
);

   seq_state_t                r_state;
   seq_state_t                w_next;
   logic [4*X_W-1:0]          r_x;
   logic [3:0][RELU_W-1:0]    r_a;       // pass A activations
   logic [3:0][AGGR_W-1:0]    r_n0;
   logic [3:0][AGGR_W-1:0]    r_n1;
   logic [3:0][OUT_W-1:0]     r_res;
   logic                      r_res_valid;
   logic                      r_err;
   logic [CNT_W-1:0]          r_done;
   logic [3:0][RELU_W-1:0]    w_relu;
   logic [3:0][AGGR_W-1:0]    w_sum;
   logic [3:0][AGGR_W-1:0]    w_max;
   logic                      w_all_ready;

   assign w_relu      = {y7_relu, y6_relu, y5_relu, y4_relu};
   assign w_all_ready = out0_n0_ready & out1_n0_ready & out0_n1_ready & out1_n1_ready;

   // While in S_AGG the relu inputs carry pass B; pass A sits in r_a.
   dnn_aggr_unit u_aggr (
      .a   (r_a),
      .b   (w_relu),
      .sum (w_sum),
      .mx  (w_max)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_next = S_Y0;
         S_Y0:    w_next = S_Y1;
         S_Y1:    w_next = S_AGG;
         S_AGG:   w_next = S_OUT;
         S_OUT:   w_next = S_CAPT;
         S_CAPT:  w_next = S_HOLD;
         S_HOLD:  if (res_ready) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Datapath mode and weight bank are pure decodes of the sequencer state.
   always_comb begin
      dnn_state = DNN_IDLE;
      case (r_state)
         S_Y0:    dnn_state = DNN0_DNN1_Y_OUT;
         S_Y1:    dnn_state = DNN2_DNN3_Y_OUT;
         S_AGG:   dnn_state = DNN_AGGR;
         S_OUT:   dnn_state = FINAL_OUT;
         default: dnn_state = DNN_IDLE;
      endcase
   end

   assign wsel     = (r_state == S_Y1) || (r_state == S_AGG);
   assign in_ready = (r_state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_x         <= '0;
         r_a         <= '0;
         r_n0        <= '0;
         r_n1        <= '0;
         r_res       <= '0;
         r_res_valid <= 1'b0;
         r_err       <= 1'b0;
         r_done      <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && in_valid)
            r_x <= x_in;
         if (r_state == S_Y1)
            r_a <= w_relu;
         if (r_state == S_AGG) begin
            r_n0 <= w_sum;
            r_n1 <= w_max;
         end
         // Datapath outputs settle on the negedge inside S_CAPT.
         if (r_state == S_CAPT) begin
            r_res       <= {out1_n1, out0_n1, out1_n0, out0_n0};
            r_res_valid <= 1'b1;
            r_done      <= r_done + {{(CNT_W-1){1'b0}}, 1'b1};
            if (!w_all_ready)
               r_err <= 1'b1;
         end else if (r_state == S_HOLD && res_ready) begin
            r_res_valid <= 1'b0;
         end
      end
   end

   assign x0 = r_x[0*X_W +: X_W];
   assign x1 = r_x[1*X_W +: X_W];
   assign x2 = r_x[2*X_W +: X_W];
   assign x3 = r_x[3*X_W +: X_W];

   assign y4_n0_aggr = r_n0[0];
   assign y5_n0_aggr = r_n0[1];
   assign y6_n0_aggr = r_n0[2];
   assign y7_n0_aggr = r_n0[3];
   assign y4_n1_aggr = r_n1[0];
   assign y5_n1_aggr = r_n1[1];
   assign y6_n1_aggr = r_n1[2];
   assign y7_n1_aggr = r_n1[3];

   assign res0_n0   = r_res[0];
   assign res1_n0   = r_res[1];
   assign res0_n1   = r_res[2];
   assign res1_n1   = r_res[3];
   assign res_valid = r_res_valid;
   assign seq_err   = r_err;
   assign done_cnt  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dnn_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dnn_seq_ctrl
//  Description : Directed self-checking bench for dnn_seq_ctrl. A small
//                behavioural datapath returns pass A / pass B activations
//                according to dnn_state; results and flags are driven directly.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dnn_seq_ctrl;
   import defines_pkg::*;

   localparam int CNT_W = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [27:0]       x_in;
   logic [6:0]        x0, x1, x2, x3;
   logic              wsel;
   dnn_state_t        dnn_state;
   logic [12:0]       y4_relu, y5_relu, y6_relu, y7_relu;
   logic [14:0]       y4_n0_aggr, y5_n0_aggr, y6_n0_aggr, y7_n0_aggr;
   logic [14:0]       y4_n1_aggr, y5_n1_aggr, y6_n1_aggr, y7_n1_aggr;
   logic [20:0]       out0_n0, out1_n0, out0_n1, out1_n1;
   logic              out0_n0_ready, out1_n0_ready, out0_n1_ready, out1_n1_ready;
   logic              res_valid;
   logic              res_ready;
   logic [20:0]       res0_n0, res1_n0, res0_n1, res1_n1;
   logic              seq_err;
   logic [CNT_W-1:0]  done_cnt;

   int checks = 0;
   int errors = 0;

   // -5, 3, 1048575, -1048576 as 21-bit two's complement
   localparam logic [20:0] C_O0 = 21'h1FFFFB;
   localparam logic [20:0] C_O1 = 21'h000003;
   localparam logic [20:0] C_O2 = 21'h0FFFFF;
   localparam logic [20:0] C_O3 = 21'h100000;

   dnn_seq_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
      .x0(x0), .x1(x1), .x2(x2), .x3(x3),
      .wsel(wsel), .dnn_state(dnn_state),
      .y4_relu(y4_relu), .y5_relu(y5_relu), .y6_relu(y6_relu), .y7_relu(y7_relu),
      .y4_n0_aggr(y4_n0_aggr), .y5_n0_aggr(y5_n0_aggr),
      .y6_n0_aggr(y6_n0_aggr), .y7_n0_aggr(y7_n0_aggr),
      .y4_n1_aggr(y4_n1_aggr), .y5_n1_aggr(y5_n1_aggr),
      .y6_n1_aggr(y6_n1_aggr), .y7_n1_aggr(y7_n1_aggr),
      .out0_n0(out0_n0), .out1_n0(out1_n0), .out0_n1(out0_n1), .out1_n1(out1_n1),
      .out0_n0_ready(out0_n0_ready), .out1_n0_ready(out1_n0_ready),
      .out0_n1_ready(out0_n1_ready), .out1_n1_ready(out1_n1_ready),
      .res_valid(res_valid), .res_ready(res_ready),
      .res0_n0(res0_n0), .res1_n0(res1_n0), .res0_n1(res0_n1), .res1_n1(res1_n1),
      .seq_err(seq_err), .done_cnt(done_cnt)
   );

   always #5 clk = ~clk;

   // Datapath model: pass A visible while in DNN2_DNN3_Y_OUT, pass B in DNN_AGGR.
   always_comb begin
      {y7_relu, y6_relu, y5_relu, y4_relu} = '0;
      if (dnn_state == DNN2_DNN3_Y_OUT)
         {y7_relu, y6_relu, y5_relu, y4_relu} = {13'd7, 13'd4095, 13'd0, 13'd100};
      else if (dnn_state == DNN_AGGR)
         {y7_relu, y6_relu, y5_relu, y4_relu} = {13'd7, 13'd0, 13'd20, 13'd50};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int acc[3];
      int n;
      logic w;

      rst = 1'b1; in_valid = 1'b0; x_in = '0; res_ready = 1'b0;
      out0_n0 = C_O0; out1_n0 = C_O1; out0_n1 = C_O2; out1_n1 = C_O3;
      out0_n0_ready = 1'b1; out1_n0_ready = 1'b1; out0_n1_ready = 1'b1; out1_n1_ready = 1'b1;
      repeat (2) tick();

      // ---- reset state
      check("rst_dnn_state", 32'(dnn_state), 32'(DNN_IDLE));
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_done_cnt", 32'(done_cnt), 32'd0);
      check("rst_seq_err", 32'(seq_err), 32'd0);
      check("rst_x0", 32'(x0), 32'd0);
      check("rst_wsel", 32'(wsel), 32'd0);
      check("rst_y4_n0", 32'(y4_n0_aggr), 32'd0);
      check("rst_res0_n0", 32'(res0_n0), 32'd0);
      rst = 1'b0;

      // ---- single sample with backpressure
      x_in = 28'h0000001; in_valid = 1'b1;
      tick();                                   // edge 0: accept
      in_valid = 1'b0;
      check("s1_ds_e0", 32'(dnn_state), 32'(DNN0_DNN1_Y_OUT));
      check("s1_wsel_e0", 32'(wsel), 32'd0);
      check("s1_in_ready_e0", 32'(in_ready), 32'd0);
      check("s1_x0", 32'(x0), 32'd1);
      check("s1_x1", 32'(x1), 32'd0);
      tick();
      check("s1_ds_e1", 32'(dnn_state), 32'(DNN2_DNN3_Y_OUT));
      check("s1_wsel_e1", 32'(wsel), 32'd1);
      tick();
      check("s1_ds_e2", 32'(dnn_state), 32'(DNN_AGGR));
      check("s1_wsel_e2", 32'(wsel), 32'd1);
      tick();
      check("s1_ds_e3", 32'(dnn_state), 32'(FINAL_OUT));
      check("y4_n0", 32'(y4_n0_aggr), 32'd150);
      check("y5_n0", 32'(y5_n0_aggr), 32'd20);
      check("y6_n0", 32'(y6_n0_aggr), 32'd4095);
      check("y7_n0", 32'(y7_n0_aggr), 32'd14);
      check("y4_n1", 32'(y4_n1_aggr), 32'd100);
      check("y5_n1", 32'(y5_n1_aggr), 32'd20);
      check("y6_n1", 32'(y6_n1_aggr), 32'd4095);
      check("y7_n1", 32'(y7_n1_aggr), 32'd7);
      tick();
      check("s1_ds_e4", 32'(dnn_state), 32'(DNN_IDLE));
      check("s1_res_valid_e4", 32'(res_valid), 32'd0);
      tick();
      check("s1_res_valid_e5", 32'(res_valid), 32'd1);
      check("s1_done_cnt", 32'(done_cnt), 32'd1);
      check("s1_seq_err", 32'(seq_err), 32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_res_valid", 32'(res_valid), 32'd1);
         check("bp_res0_n0", 32'(res0_n0), 32'(C_O0));
         check("bp_res1_n0", 32'(res1_n0), 32'(C_O1));
         check("bp_res0_n1", 32'(res0_n1), 32'(C_O2));
         check("bp_res1_n1", 32'(res1_n1), 32'(C_O3));
      end
      res_ready = 1'b1;
      tick();
      check("bp_release_valid", 32'(res_valid), 32'd0);
      check("bp_release_in_ready", 32'(in_ready), 32'd1);

      // ---- capture with a low ready flag
      x_in = 28'h1234567; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("s2_x0", 32'(x0), 32'h67);
      check("s2_x1", 32'(x1), 32'h0A);
      repeat (4) tick();                        // now in S_CAPT
      out1_n1_ready = 1'b0;
      tick();
      out1_n1_ready = 1'b1;
      check("s2_seq_err", 32'(seq_err), 32'd1);
      check("s2_done_cnt", 32'(done_cnt), 32'd2);
      check("s2_res_valid", 32'(res_valid), 32'd1);
      tick();
      check("s2_in_ready", 32'(in_ready), 32'd1);

      // ---- clean sample: seq_err must stay set
      x_in = '0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      check("s3_seq_err_sticky", 32'(seq_err), 32'd1);
      check("s3_done_cnt", 32'(done_cnt), 32'd3);
      tick();

      // ---- reset in the middle of S_AGG
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (2) tick();
      check("mr_in_agg", 32'(dnn_state), 32'(DNN_AGGR));
      check("mr_old_aggr", 32'(y4_n0_aggr), 32'd150);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_ds", 32'(dnn_state), 32'(DNN_IDLE));
      check("mr_in_ready", 32'(in_ready), 32'd1);
      check("mr_res_valid", 32'(res_valid), 32'd0);
      check("mr_done_cnt", 32'(done_cnt), 32'd0);
      check("mr_seq_err", 32'(seq_err), 32'd0);
      check("mr_n0_all", 32'({y7_n0_aggr, y6_n0_aggr} | {y5_n0_aggr, y4_n0_aggr}), 32'd0);
      check("mr_n1_all", 32'({y7_n1_aggr, y6_n1_aggr} | {y5_n1_aggr, y4_n1_aggr}), 32'd0);

      // ---- back-to-back samples
      res_ready = 1'b1;
      in_valid  = 1'b1;
      n = 0;
      for (int c = 0; c < 60 && n < 3; c++) begin
         w = in_ready && in_valid;
         if (w && n > 0)
            check("b2b_done_at_accept", 32'(done_cnt), 32'(n));
         tick();
         if (w) begin
            acc[n] = c;
            n++;
            if (n == 3) in_valid = 1'b0;
         end
      end
      in_valid = 1'b0;
      check("b2b_accepts", 32'(n), 32'd3);
      if (n == 3) begin
         check("b2b_gap01", 32'(acc[1] - acc[0]), 32'd7);
         check("b2b_gap12", 32'(acc[2] - acc[1]), 32'd7);
      end
      for (int c = 0; c < 20 && !res_valid; c++) tick();
      check("b2b_final_valid", 32'(res_valid), 32'd1);
      check("b2b_final_done", 32'(done_cnt), 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/dnn_seq_ctrl.md
Name: dnn_seq_ctrl

Overview:
Sequencer and aggregator on the far side of the shared dnn datapath. It accepts one input sample through a valid/ready handshake and drives dnn_state, the input vector and the weight-bank select through two hidden-layer passes. It captures and combines the ReLU activations into the y*_n0_aggr and y*_n1_aggr operands, triggers the FINAL_OUT pass, and returns the four 21-bit outputs through a result valid/ready handshake with backpressure.

Parameters:
CNT_W, 16, width of the completed-sample counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  sample offered
in_ready  out  1  block can accept a sample
x_in  in  28  {x3,x2,x1,x0}, 7-bit signed each
x0, x1, x2, x3  out  7 each  latched sample to datapath
wsel  out  1  weight bank: 0 = pass A (DNN0/DNN1), 1 = pass B (DNN2/DNN3)
dnn_state  out  dnn_state_t  datapath mode
y4_relu, y5_relu, y6_relu, y7_relu  in  13 each  datapath ReLU outputs
y4_n0_aggr .. y7_n0_aggr  out  15 each  aggregate operands, network 0
y4_n1_aggr .. y7_n1_aggr  out  15 each  aggregate operands, network 1
out0_n0, out1_n0, out0_n1, out1_n1  in  21 each  datapath outputs
out0_n0_ready, out1_n0_ready, out0_n1_ready, out1_n1_ready  in  1 each  datapath output flags
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
res0_n0, res1_n0, res0_n1, res1_n1  out  21 each  held results
seq_err  out  1  sticky: a datapath ready flag was low at capture
done_cnt  out  CNT_W  completed-sample count, wraps

Behaviour:
- Reset values (synchronous, rst=1 at a posedge): state IDLE; dnn_state=DNN_IDLE; x0..x3=0; wsel=0; all aggr outputs 0; A-bank registers 0; res*=0; res_valid=0; seq_err=0; done_cnt=0. in_ready is combinational and equals (state==IDLE).
- Reset mid-operation: aborts any sequence, drops res_valid, and discards partial A-bank and aggr contents.
- IDLE: dnn_state=DNN_IDLE. When in_valid&in_ready: latch x_in into x0..x3, go to S_Y0. x0..x3 hold until the next accept.
- S_Y0: dnn_state=DNN0_DNN1_Y_OUT, wsel=0. Next state S_Y1.
- S_Y1: dnn_state=DNN2_DNN3_Y_OUT, wsel=1. y*_relu now carry pass A; latch them into A-bank (13-bit, non-negative). Next state S_AGG.
- S_AGG: dnn_state=DNN_AGGR, wsel=1. y*_relu now carry pass B (B[k]). Register:
  - yk_n0_aggr = zext15(A[k]) + zext15(B[k]); maximum 8190, no overflow.
  - yk_n1_aggr = zext15(max(A[k],B[k])).
  - Next state S_OUT.
- S_OUT: dnn_state=FINAL_OUT; aggr outputs held stable for the whole cycle. Next state S_CAPT.
- S_CAPT: dnn_state=DNN_IDLE. The datapath updates its outputs on the negedge inside this cycle. At the closing posedge:
  - copy out* into res*;
  - set res_valid;
  - done_cnt increments, wrapping to 0 at 2^CNT_W-1;
  - if any of the four out*_ready flags is 0, set seq_err (cleared only by rst).
  - Next state S_HOLD.
- S_HOLD: res_valid=1 and res* stable until res_valid&res_ready. On that edge, clear res_valid and go to IDLE. in_ready=0 while in S_HOLD.
- Latency: the accept edge is edge 0; res_valid is first high after edge 5. Minimum initiation interval is 7 cycles, when res_ready is already high.
- in_valid asserted during a busy state is ignored; the producer holds it until in_ready=1.
- Aggr outputs keep their last value outside S_AGG/S_OUT.

Decomposition:
- defines_pkg: extend dnn_state_t with DNN_IDLE and DNN_AGGR (3-bit enum); add the seq_state_t enum {IDLE, S_Y0, S_Y1, S_AGG, S_OUT, S_CAPT, S_HOLD} and localparams RELU_W=13, AGGR_W=15, OUT_W=21.
- One sub-module: dnn_aggr_unit, a purely combinational per-neuron sum and max over four lanes, instantiated once by the controller, which registers its outputs in S_AGG.

Test Plan:
- Reset, then a single sample: x_in=0x0000001 with in_valid for one cycle -> dnn_state sequence DNN0_DNN1_Y_OUT, DNN2_DNN3_Y_OUT, DNN_AGGR, FINAL_OUT, DNN_IDLE on consecutive cycles; wsel sequence 0,1,1; res_valid is first high after edge 5; done_cnt=1.
- Aggregation: model returns pass A relu=[100,0,4095,7] and pass B relu=[50,20,0,7] -> n0_aggr=[150,20,4095,14] and n1_aggr=[100,20,4095,7] during S_OUT.
- Backpressure: hold res_ready=0 for 10 cycles with model outputs -5, 3, 1048575, -1048576 -> res* stable at those values, in_ready=0 throughout; res_ready=1 -> res_valid drops next edge and in_ready=1.
- Reset mid S_AGG: assert rst for one cycle -> state IDLE, all aggr outputs 0, res_valid=0, done_cnt=0 on the following cycle.
- Capture check: force out1_n1_ready=0 during S_CAPT -> seq_err=1 and stays 1 across the next clean sample until rst.
- Back-to-back: in_valid held high and res_ready=1 for 3 samples -> accepts spaced exactly 7 cycles apart; done_cnt counts 1,2,3.
